muldiv_unit: RTL and testbench

- Multi-cycle integer multiply/divide unit sitting beside the execute stage.
- Consumes the two register-file read ports (rd1/rd2) as operands.
- Drives the register-file write port (we/wa/wd) directly for one cycle when its result is ready.
- The pipeline stalls on busy while an operation is in flight.

---
 rtl/muldiv_unit.sv | 147 ++++++++++++++
 tb/tb_muldiv_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle shift-add multiplier / restoring divider feeding the RF write port.
// Define MULDIV_DIV_EN to build the divider datapath; otherwise div ops write 0.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int AW    = 3,
    parameter int CNTW  = 6
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [AW-1:0]    dst,
    output logic             busy,
    output logic             wb_we,
    output logic [AW-1:0]    wb_wa,
    output logic [WIDTH-1:0] wb_wd,
    output logic             div_by_zero
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_WB   = 2'b10;

    localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

    logic [1:0]         state;
    logic [CNTW-1:0]    cnt;
    logic [1:0]         op_q;
    logic [AW-1:0]      dst_q;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] step_next;
    logic [WIDTH-1:0]   result;

`ifdef MULDIV_DIV_EN
    logic               dz_q;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] div_next;
`endif

    assign busy  = (state != S_IDLE);
    assign wb_we = (state == S_WB);

`ifdef MULDIV_DIV_EN
    assign div_by_zero = (state == S_WB) & dz_q;
`else
    assign div_by_zero = 1'b0;
`endif

    // One iteration of the active algorithm; acc holds {hi, lo} or {rem, quot}.
    always_comb begin
        add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {add_sum, acc[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        // A zero divisor always "fits", so quot ends all-ones and rem ends
        // equal to the dividend without any special casing.
        trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};
        if (!trial[WIDTH])
            div_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            div_next = {acc[2*WIDTH-2:0], 1'b0};
        step_next = op_q[1] ? div_next : mul_next;
`else
        step_next = mul_next;
`endif
    end

    // Select the word to write back from the final iteration's value.
    always_comb begin
        result = '0;
        unique case (op_q)
            2'b00: result = step_next[WIDTH-1:0];
            2'b01: result = step_next[2*WIDTH-1:WIDTH];
`ifdef MULDIV_DIV_EN
            2'b10: result = step_next[WIDTH-1:0];
            2'b11: result = step_next[2*WIDTH-1:WIDTH];
`else
            2'b10: result = '0;
            2'b11: result = '0;
`endif
            default: result = '0;
        endcase
    end

    // Sequencer: latch in IDLE, iterate WIDTH times in RUN, pulse write in WB.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_q  <= '0;
            dst_q <= '0;
            opnd  <= '0;
            acc   <= '0;
            wb_wa <= '0;
            wb_wd <= '0;
`ifdef MULDIV_DIV_EN
            dz_q  <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        dst_q <= dst;
                        cnt   <= '0;
                        state <= S_RUN;
`ifdef MULDIV_DIV_EN
                        dz_q  <= op[1] & (src_b == '0);
                        if (op[1]) begin
                            opnd <= src_b;
                            acc  <= {{WIDTH{1'b0}}, src_a};
                        end else begin
                            opnd <= src_a;
                            acc  <= {{WIDTH{1'b0}}, src_b};
                        end
`else
                        opnd  <= src_a;
                        acc   <= {{WIDTH{1'b0}}, src_b};
`endif
                    end
                end
                S_RUN: begin
                    acc <= step_next;
                    if (cnt == LAST) begin
                        wb_wd <= result;
                        wb_wa <= dst_q;
                        state <= S_WB;
                    end else begin
                        cnt <= cnt + CNTW'(1);
                    end
                end
                S_WB: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic model.
// Div expectations follow whether MULDIV_DIV_EN is defined for the build.
module tb_muldiv_unit;

    logic        clk;
    logic        n_rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [2:0]  dst;
    logic        busy;
    logic        wb_we;
    logic [2:0]  wb_wa;
    logic [31:0] wb_wd;
    logic        div_by_zero;

    int n_checks;
    int n_pass;

    muldiv_unit #(.WIDTH(32), .AW(3), .CNTW(6)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .dst         (dst),
        .busy        (busy),
        .wb_we       (wb_we),
        .wb_wa       (wb_wa),
        .wb_wd       (wb_wd),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Returns {div_by_zero, write data} from plain integer arithmetic.
    function automatic logic [32:0] model(input logic [1:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (o)
            2'd0: return {1'b0, p[31:0]};
            2'd1: return {1'b0, p[63:32]};
`ifdef MULDIV_DIV_EN
            2'd2: return (b == 0) ? {1'b1, 32'hFFFF_FFFF} : {1'b0, a / b};
            default: return (b == 0) ? {1'b1, a} : {1'b0, a % b};
`else
            default: return 33'd0;
`endif
        endcase
    endfunction

    // Issue one op, then watch busy / write-back cycle by cycle.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] d, input bit pulse_again);
        logic [32:0] exp;
        int cyc;
        bit busy_ok;
        exp = model(o, a, b);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b; dst = d;
        @(negedge clk);
        cyc = 1;
        busy_ok = 1'b1;
        while (!wb_we && cyc < 40) begin
            if (!busy) busy_ok = 1'b0;
            if (div_by_zero) busy_ok = 1'b0;
            if (pulse_again) begin
                start = (cyc == 10);
                op = 2'd0; src_a = 32'd9; src_b = 32'd9; dst = 3'd6;
            end else begin
                start = 1'($urandom);
                op = 2'($urandom);
                src_a = $urandom; src_b = $urandom; dst = 3'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(cyc), 64'd33);
        check({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
        check({tag, "_busy_wb"}, 64'(busy), 64'd1);
        check({tag, "_wa"}, 64'(wb_wa), 64'(d));
        check({tag, "_wd"}, 64'(wb_wd), 64'(exp[31:0]));
        check({tag, "_dz"}, 64'(div_by_zero), 64'(exp[32]));
        @(negedge clk);
        check({tag, "_we_after"}, {62'd0, wb_we, busy}, 64'd0);
        check({tag, "_dz_after"}, 64'(div_by_zero), 64'd0);
        check({tag, "_wd_hold"}, 64'(wb_wd), 64'(exp[31:0]));
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int seen_we;
        n_checks = 0;
        n_pass = 0;
        n_rst = 1'b0;
        start = 1'b0;
        op = 2'd0;
        src_a = '0;
        src_b = '0;
        dst = '0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {busy, wb_we, div_by_zero, wb_wa, wb_wd},
              {3'b000, 3'd0, 32'd0});
        n_rst = 1'b1;

        run_op("mul_7x6", 2'd0, 32'd7, 32'd6, 3'd3, 1'b0);
        run_op("mul_ff", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 1'b0);
        run_op("mulhu_ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 1'b0);
        run_op("divu_100_7", 2'd2, 32'd100, 32'd7, 3'd5, 1'b0);
        run_op("remu_100_7", 2'd3, 32'd100, 32'd7, 3'd5, 1'b0);
        run_op("divu_5_0", 2'd2, 32'd5, 32'd0, 3'd4, 1'b0);
        run_op("remu_5_0", 2'd3, 32'd5, 32'd0, 3'd4, 1'b0);
        run_op("mul_busy_start", 2'd0, 32'd3, 32'd4, 3'd2, 1'b1);
        run_op("mul_at_e34", 2'd0, 32'd5, 32'd5, 3'd7, 1'b0);

        // Reset in the middle of RUN must abort without a write.
        @(negedge clk);
        start = 1'b1; op = 2'd0; src_a = 32'd3; src_b = 32'd4; dst = 3'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        #1 n_rst = 1'b0;
        #1;
        check("rst_mid_comb", {61'd0, busy, wb_we, div_by_zero}, 64'd0);
        seen_we = 0;
        repeat (2) begin
            @(negedge clk);
            if (wb_we) seen_we++;
        end
        n_rst = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (wb_we || busy) seen_we++;
        end
        check("rst_mid_no_we", 64'(seen_we), 64'd0);
        check("rst_mid_wd", 64'(wb_wd), 64'd0);
        run_op("mul_after_rst", 2'd0, 32'd3, 32'd4, 3'd2, 1'b0);

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            run_op($sformatf("rnd%0d", i), ro, ra, rb, 3'($urandom), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
